lsu_bus_master: RTL and testbench

- Memory-stage load/store unit for the RV32I pipeline. Turns MemRead/MemWrite in the M stage into a valid/ready bus transaction toward variable-latency data memory.
- It is the requester end of the stall protocol. StallMemM goes to the hazard control unit, which freezes F/D/E/M and bubbles W while an access is outstanding.
- Also performs byte-lane steering, write-strobe generation, load sign/zero extension, and misalignment and fault detection.

---
 rtl/lsu_pkg.sv | 33 +++
 rtl/lsu_bus_master_if.sv | 27 ++
 rtl/load_extend.sv | 29 ++
 rtl/lsu_bus_master.sv | 153 +++++++++++++++
 tb/tb_lsu_bus_master.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared funct3 codes, FSM state type and access-legality helpers
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } lsu_state_e;

  function automatic logic legal_f3(input logic is_store, input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W: legal_f3 = 1'b1;
      F3_BU, F3_HU:     legal_f3 = ~is_store;
      default:          legal_f3 = 1'b0;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    case (f3[1:0])
      2'b01:   misaligned = addr_lo[0];
      2'b10:   misaligned = (addr_lo != 2'b00);
      default: misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_bus_master_if.sv
// rtl/lsu_bus_master_if.sv - valid/ready data-memory bus between the LSU and memory
interface lsu_bus_master_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);

  logic              bus_req_valid;
  logic              bus_req_ready;
  logic              bus_req_we;
  logic [ADDR_W-1:0] bus_req_addr;
  logic [XLEN-1:0]   bus_req_wdata;
  logic [3:0]        bus_req_wstrb;
  logic              bus_rsp_valid;
  logic [XLEN-1:0]   bus_rsp_rdata;
  logic              bus_rsp_err;

  modport master (
    output bus_req_valid, bus_req_we, bus_req_addr, bus_req_wdata, bus_req_wstrb,
    input  bus_req_ready, bus_rsp_valid, bus_rsp_rdata, bus_rsp_err
  );

  modport slave (
    input  bus_req_valid, bus_req_we, bus_req_addr, bus_req_wdata, bus_req_wstrb,
    output bus_req_ready, bus_rsp_valid, bus_rsp_rdata, bus_rsp_err
  );

endinterface

// File: rtl/load_extend.sv
// rtl/load_extend.sv - selects the addressed byte/half of a read word and sign/zero extends it
module load_extend
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_data,
  input  logic [1:0]      i_addr_lo,
  input  logic [2:0]      i_funct3,
  output logic [XLEN-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_data[{i_addr_lo, 3'b000} +: 8];
    w_half = i_addr_lo[1] ? i_data[31:16] : i_data[15:0];
    case (i_funct3)
      F3_B:    o_data = {{(XLEN-8){w_byte[7]}}, w_byte};
      F3_H:    o_data = {{(XLEN-16){w_half[15]}}, w_half};
      F3_W:    o_data = i_data;
      F3_BU:   o_data = {{(XLEN-8){1'b0}}, w_byte};
      F3_HU:   o_data = {{(XLEN-16){1'b0}}, w_half};
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/lsu_bus_master.sv
// rtl/lsu_bus_master.sv - M-stage load/store unit: issues valid/ready bus accesses and stalls the pipe
module lsu_bus_master
  import lsu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              MemReadM,
  input  logic              MemWriteM,
  input  logic [2:0]        funct3M,
  input  logic [ADDR_W-1:0] ALUResultM,
  input  logic [XLEN-1:0]   WriteDataM,
  output logic [XLEN-1:0]   ReadDataM,
  output logic              StallMemM,
  output logic              MisalignM,
  output logic              FaultM,
  lsu_bus_master_if.master  bus
);

  localparam int              CNT_W     = $clog2(TIMEOUT + 2);
  localparam int              TO_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TO_LAST_I);

  lsu_state_e        r_state;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [XLEN-1:0]   r_wdata;
  logic [3:0]        r_wstrb;
  logic [2:0]        r_funct3;
  logic [1:0]        r_addr_lo;
  logic [CNT_W-1:0]  r_cnt;
  logic [XLEN-1:0]   r_rdata;
  logic              r_err;

  logic              w_idle;
  logic              w_access;
  logic              w_is_store;
  logic              w_illegal;
  logic              w_misal;
  logic              w_start;
  logic              w_timeout;
  logic [ADDR_W-1:0] w_addr;
  logic [XLEN-1:0]   w_wdata;
  logic [3:0]        w_wstrb;
  logic [XLEN-1:0]   w_ext;

  // Read wins when both strobes are set, so a store is only a pure write.
  assign w_idle     = (r_state == ST_IDLE);
  assign w_access   = MemReadM | MemWriteM;
  assign w_is_store = MemWriteM & ~MemReadM;
  assign w_illegal  = w_access & ~legal_f3(w_is_store, funct3M);
  assign w_misal    = w_access & ~w_illegal & misaligned(funct3M, ALUResultM[1:0]);
  assign w_start    = reset_n & w_idle & w_access & ~w_illegal & ~w_misal;
  assign w_timeout  = (TIMEOUT != 0) && (r_cnt >= TO_LAST);
  assign w_addr     = {ALUResultM[ADDR_W-1:2], 2'b00};

  always_comb begin
    w_wstrb = 4'b0000;
    w_wdata = WriteDataM;
    case (funct3M[1:0])
      2'b00: begin
        w_wstrb = 4'b0001 << ALUResultM[1:0];
        w_wdata = {4{WriteDataM[7:0]}};
      end
      2'b01: begin
        w_wstrb = 4'b0011 << {ALUResultM[1], 1'b0};
        w_wdata = {2{WriteDataM[15:0]}};
      end
      default: begin
        w_wstrb = 4'b1111;
        w_wdata = WriteDataM;
      end
    endcase
    if (!w_is_store) w_wstrb = 4'b0000;
  end

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .i_data    (bus.bus_rsp_rdata),
    .i_addr_lo (r_addr_lo),
    .i_funct3  (r_funct3),
    .o_data    (w_ext)
  );

  // The first request cycle is presented straight from the M-stage inputs; later cycles replay the captured copy.
  assign bus.bus_req_valid = w_start | (r_state == ST_REQ);
  assign bus.bus_req_we    = w_start ? w_is_store : r_we;
  assign bus.bus_req_addr  = w_start ? w_addr     : r_addr;
  assign bus.bus_req_wdata = w_start ? w_wdata    : r_wdata;
  assign bus.bus_req_wstrb = w_start ? w_wstrb    : r_wstrb;

  assign StallMemM = w_start | (r_state == ST_REQ) | (r_state == ST_WAIT);
  assign MisalignM = reset_n & w_idle & w_misal;
  assign FaultM    = reset_n & ((w_idle & w_illegal) | ((r_state == ST_DONE) & r_err));
  assign ReadDataM = (r_state == ST_DONE) ? r_rdata : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= 4'b0000;
      r_funct3  <= 3'b000;
      r_addr_lo <= 2'b00;
      r_cnt     <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_we      <= w_is_store;
            r_addr    <= w_addr;
            r_wdata   <= w_wdata;
            r_wstrb   <= w_wstrb;
            r_funct3  <= funct3M;
            r_addr_lo <= ALUResultM[1:0];
            r_cnt     <= '0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
            r_state   <= bus.bus_req_ready ? ST_WAIT : ST_REQ;
          end
        end
        ST_REQ: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (bus.bus_req_ready) begin
            r_state <= ST_WAIT;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_WAIT: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (bus.bus_rsp_valid) begin
            r_rdata <= r_we ? '0 : w_ext;
            r_err   <= bus.bus_rsp_err;
            r_state <= ST_DONE;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_bus_master.sv
// tb/tb_lsu_bus_master.sv - directed self-checking bench for lsu_bus_master
module tb_lsu_bus_master;
  import lsu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        a_rd, a_wr, b_rd, b_wr;
  logic [2:0]  a_f3, b_f3;
  logic [31:0] a_addr, a_wd, a_rdo, b_addr, b_wd, b_rdo;
  logic        a_stall, a_mis, a_flt, b_stall, b_mis, b_flt;

  lsu_bus_master_if ifa ();
  lsu_bus_master_if ifb ();

  lsu_bus_master u_a (
    .clk (clk), .reset_n (reset_n),
    .MemReadM (a_rd), .MemWriteM (a_wr), .funct3M (a_f3),
    .ALUResultM (a_addr), .WriteDataM (a_wd), .ReadDataM (a_rdo),
    .StallMemM (a_stall), .MisalignM (a_mis), .FaultM (a_flt),
    .bus (ifa)
  );

  lsu_bus_master #(.TIMEOUT(4)) u_b (
    .clk (clk), .reset_n (reset_n),
    .MemReadM (b_rd), .MemWriteM (b_wr), .funct3M (b_f3),
    .ALUResultM (b_addr), .WriteDataM (b_wd), .ReadDataM (b_rdo),
    .StallMemM (b_stall), .MisalignM (b_mis), .FaultM (b_flt),
    .bus (ifb)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic acc(input logic rd, input logic wr, input logic [2:0] f3,
                     input logic [31:0] ad, input logic [31:0] wd);
    a_rd = rd; a_wr = wr; a_f3 = f3; a_addr = ad; a_wd = wd;
  endtask

  task automatic bus_in(input logic rdy, input logic rv, input logic [31:0] rdat, input logic er);
    ifa.bus_req_ready = rdy; ifa.bus_rsp_valid = rv; ifa.bus_rsp_rdata = rdat; ifa.bus_rsp_err = er;
  endtask

  initial begin
    reset_n = 1'b0;
    acc(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    bus_in(1'b0, 1'b0, 32'h0, 1'b0);
    b_rd = 1'b0; b_wr = 1'b0; b_f3 = 3'b000; b_addr = 32'h0; b_wd = 32'h0;
    ifb.bus_req_ready = 1'b0; ifb.bus_rsp_valid = 1'b0; ifb.bus_rsp_rdata = 32'h0; ifb.bus_rsp_err = 1'b0;

    @(negedge clk); #1;
    chk("rst_stall", {31'b0, a_stall}, 32'd0);
    chk("rst_valid", {31'b0, ifa.bus_req_valid}, 32'd0);
    chk("rst_rdata", a_rdo, 32'h0);
    chk("rst_fault", {31'b0, a_flt}, 32'd0);
    @(negedge clk); reset_n = 1'b1;

    // LW 0x100, ready on request, response next cycle
    @(negedge clk); acc(1, 0, F3_W, 32'h100, 0); bus_in(1, 0, 0, 0); #1;
    chk("lw_stall0", {31'b0, a_stall}, 32'd1);
    chk("lw_valid0", {31'b0, ifa.bus_req_valid}, 32'd1);
    chk("lw_addr", ifa.bus_req_addr, 32'h100);
    chk("lw_we", {31'b0, ifa.bus_req_we}, 32'd0);
    @(negedge clk); bus_in(0, 1, 32'hDEADBEEF, 0); #1;
    chk("lw_stall1", {31'b0, a_stall}, 32'd1);
    chk("lw_valid1", {31'b0, ifa.bus_req_valid}, 32'd0);
    @(negedge clk); bus_in(0, 0, 0, 0); #1;
    chk("lw_done_stall", {31'b0, a_stall}, 32'd0);
    chk("lw_done_data", a_rdo, 32'hDEADBEEF);
    chk("lw_done_fault", {31'b0, a_flt}, 32'd0);
    @(negedge clk); acc(0, 0, 0, 0, 0); #1;
    chk("lw_after_data", a_rdo, 32'h0);

    // LB 0x103 then LBU 0x103 back to back
    @(negedge clk); acc(1, 0, F3_B, 32'h103, 0); bus_in(1, 0, 0, 0); #1;
    chk("lb_addr", ifa.bus_req_addr, 32'h100);
    @(negedge clk); bus_in(0, 1, 32'h80FF0000, 0);
    @(negedge clk); bus_in(0, 0, 0, 0); #1;
    chk("lb_data", a_rdo, 32'hFFFFFF80);
    @(negedge clk); acc(1, 0, F3_BU, 32'h103, 0); bus_in(1, 0, 0, 0); #1;
    chk("lbu_valid", {31'b0, ifa.bus_req_valid}, 32'd1);
    @(negedge clk); bus_in(0, 1, 32'h80FF0000, 0);
    @(negedge clk); bus_in(0, 0, 0, 0); #1;
    chk("lbu_data", a_rdo, 32'h00000080);

    // LH 0x102 sign-extends the upper half
    @(negedge clk); acc(1, 0, F3_H, 32'h102, 0); bus_in(1, 0, 0, 0);
    @(negedge clk); bus_in(0, 1, 32'h80011234, 0);
    @(negedge clk); bus_in(0, 0, 0, 0); #1;
    chk("lh_data", a_rdo, 32'hFFFF8001);

    // SH 0x202 with ready held off; inputs scrambled while in REQ
    @(negedge clk); acc(0, 1, F3_H, 32'h202, 32'h1234ABCD); bus_in(0, 0, 0, 0); #1;
    chk("sh_valid0", {31'b0, ifa.bus_req_valid}, 32'd1);
    chk("sh_we0", {31'b0, ifa.bus_req_we}, 32'd1);
    chk("sh_addr0", ifa.bus_req_addr, 32'h200);
    chk("sh_wstrb0", {28'b0, ifa.bus_req_wstrb}, 32'hC);
    chk("sh_wdata0", ifa.bus_req_wdata, 32'hABCDABCD);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); acc(0, 1, F3_B, 32'hFFFFFFFD, 32'h55555555); bus_in(k == 2, 0, 0, 0); #1;
      chk("sh_req_valid", {31'b0, ifa.bus_req_valid}, 32'd1);
      chk("sh_req_stall", {31'b0, a_stall}, 32'd1);
      chk("sh_req_addr", ifa.bus_req_addr, 32'h200);
      chk("sh_req_wstrb", {28'b0, ifa.bus_req_wstrb}, 32'hC);
      chk("sh_req_wdata", ifa.bus_req_wdata, 32'hABCDABCD);
    end
    @(negedge clk); bus_in(0, 1, 32'h0, 0); #1;
    chk("sh_wait_valid", {31'b0, ifa.bus_req_valid}, 32'd0);
    chk("sh_wait_stall", {31'b0, a_stall}, 32'd1);
    @(negedge clk); bus_in(0, 0, 0, 0); #1;
    chk("sh_done_stall", {31'b0, a_stall}, 32'd0);
    chk("sh_done_data", a_rdo, 32'h0);

    // SB 0x101
    @(negedge clk); acc(0, 1, F3_B, 32'h101, 32'h000000EF); bus_in(1, 0, 0, 0); #1;
    chk("sb_addr", ifa.bus_req_addr, 32'h100);
    chk("sb_wstrb", {28'b0, ifa.bus_req_wstrb}, 32'h2);
    chk("sb_wdata", ifa.bus_req_wdata, 32'hEFEFEFEF);
    @(negedge clk); bus_in(0, 1, 0, 0);
    @(negedge clk); bus_in(0, 0, 0, 0);

    // Misaligned LW, illegal load funct3, illegal store funct3
    @(negedge clk); acc(1, 0, F3_W, 32'h101, 0); #1;
    chk("mis_flag", {31'b0, a_mis}, 32'd1);
    chk("mis_valid", {31'b0, ifa.bus_req_valid}, 32'd0);
    chk("mis_stall", {31'b0, a_stall}, 32'd0);
    chk("mis_fault", {31'b0, a_flt}, 32'd0);
    @(negedge clk); acc(1, 0, 3'b011, 32'h100, 0); #1;
    chk("ill_fault", {31'b0, a_flt}, 32'd1);
    chk("ill_valid", {31'b0, ifa.bus_req_valid}, 32'd0);
    chk("ill_stall", {31'b0, a_stall}, 32'd0);
    chk("ill_mis", {31'b0, a_mis}, 32'd0);
    @(negedge clk); acc(0, 1, F3_BU, 32'h100, 0); #1;
    chk("ills_fault", {31'b0, a_flt}, 32'd1);
    chk("ills_valid", {31'b0, ifa.bus_req_valid}, 32'd0);
    @(negedge clk); acc(0, 0, 0, 0, 0); #1;
    chk("idle_fault", {31'b0, a_flt}, 32'd0);
    chk("idle_valid", {31'b0, ifa.bus_req_valid}, 32'd0);

    // Bus error on a read
    @(negedge clk); acc(1, 0, F3_W, 32'h300, 0); bus_in(1, 0, 0, 0);
    @(negedge clk); bus_in(0, 1, 32'h12345678, 1);
    @(negedge clk); bus_in(0, 0, 0, 0); #1;
    chk("err_fault", {31'b0, a_flt}, 32'd1);
    chk("err_stall", {31'b0, a_stall}, 32'd0);
    @(negedge clk); acc(0, 0, 0, 0, 0); #1;
    chk("err_clear", {31'b0, a_flt}, 32'd0);

    // Timeout on the TIMEOUT=4 instance, slave never ready
    @(negedge clk); b_rd = 1'b1; b_f3 = F3_W; b_addr = 32'h400; #1;
    chk("to_valid0", {31'b0, ifb.bus_req_valid}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      chk("to_req_valid", {31'b0, ifb.bus_req_valid}, 32'd1);
      chk("to_req_stall", {31'b0, b_stall}, 32'd1);
    end
    @(negedge clk); #1;
    chk("to_done_valid", {31'b0, ifb.bus_req_valid}, 32'd0);
    chk("to_done_fault", {31'b0, b_flt}, 32'd1);
    chk("to_done_stall", {31'b0, b_stall}, 32'd0);
    chk("to_done_data", b_rdo, 32'h0);
    @(negedge clk); b_rd = 1'b0; #1;
    chk("to_clear", {31'b0, b_flt}, 32'd0);

    // Reset while in WAIT, then a clean LW
    @(negedge clk); acc(1, 0, F3_W, 32'h100, 0); bus_in(1, 0, 0, 0);
    @(negedge clk); bus_in(0, 0, 0, 0); #1;
    chk("rw_stall", {31'b0, a_stall}, 32'd1);
    reset_n = 1'b0; #1;
    chk("rw_stall_rst", {31'b0, a_stall}, 32'd0);
    chk("rw_valid_rst", {31'b0, ifa.bus_req_valid}, 32'd0);
    chk("rw_data_rst", a_rdo, 32'h0);
    chk("rw_mis_rst", {31'b0, a_mis}, 32'd0);
    chk("rw_flt_rst", {31'b0, a_flt}, 32'd0);
    @(negedge clk); acc(0, 0, 0, 0, 0);
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk); acc(1, 0, F3_W, 32'h104, 0); bus_in(1, 0, 0, 0); #1;
    chk("rw_new_valid", {31'b0, ifa.bus_req_valid}, 32'd1);
    chk("rw_new_addr", ifa.bus_req_addr, 32'h104);
    @(negedge clk); bus_in(0, 1, 32'h11223344, 0);
    @(negedge clk); bus_in(0, 0, 0, 0); #1;
    chk("rw_new_data", a_rdo, 32'h11223344);
    chk("rw_new_stall", {31'b0, a_stall}, 32'd0);
    @(negedge clk); acc(0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
